// File: rtl/slave_ram_reader.sv
// ---------------------------------------------------------------------------
// slave_ram_reader
//
// Read-only bus master for the accelerator's external slave memory port.
// Accepts a burst command (base byte address, word count, access size),
// issues one read per word on channel 0 of the slave port, waits for
// Sout_DataRdy[0], and streams each word out with a valid/ready handshake.
// A per-access wait counter aborts the burst with a one-cycle error pulse
// if the memory never answers. A completed burst ends with a one-cycle
// done pulse.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_base_addr           byte address of the first word
//   cmd_count               words to read (0 completes immediately)
//   cmd_size                bits per access: 8/16/32/64, anything else = 64
//   S_oe_ram, S_we_ram      per-channel read/write enables (write never used)
//   S_addr_ram              per-channel addresses, channel 0 in the low field
//   S_Wdata_ram             write data, tied to zero
//   S_data_ram_size         per-channel access size, channel 0 in the low field
//   Sout_Rdata_ram          per-channel read data
//   Sout_DataRdy            per-channel read-data valid
//   out_valid/out_ready     read-word stream handshake
//   out_data                read word, zero-extended above cmd_size bits
//   out_last                set on the final word of a command
//   done, error             one-cycle completion / timeout pulses
// ---------------------------------------------------------------------------
module slave_ram_reader #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 64,
    parameter int SIZE_W   = 7,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_W-1:0]            cmd_base_addr,
    input  logic [CNT_W-1:0]             cmd_count,
    input  logic [SIZE_W-1:0]            cmd_size,
    output logic [CHANNELS-1:0]          S_oe_ram,
    output logic [CHANNELS-1:0]          S_we_ram,
    output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
    output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
    output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
    input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [CHANNELS-1:0]          Sout_DataRdy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last,
    output logic                         done,
    output logic                         error
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_OUT  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [SIZE_W-1:0]   size_q,  size_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic [ADDR_W-1:0]   addr_step;

    // Unsupported sizes collapse to a full 64-bit access, so the rest of the
    // block only ever sees one of four legal sizes.
    function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] sz);
        if (sz == SIZE_W'(8) || sz == SIZE_W'(16) || sz == SIZE_W'(32)) begin
            return sz;
        end
        return SIZE_W'(64);
    endfunction

    // Keep the low sz bits of the read word, zero everything above.
    function automatic logic [DATA_W-1:0] mask_word(input logic [DATA_W-1:0] d,
                                                    input logic [SIZE_W-1:0] sz);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i < int'(sz));
        end
        return d & m;
    endfunction

    // Byte stride between consecutive words; the address wraps silently.
    assign addr_step = ADDR_W'(size_q >> 3);

    // Only channel 0 is ever used; the other channels' returns are ignored.
    logic unused_inputs;
    assign unused_inputs = ^{Sout_Rdata_ram[CHANNELS*DATA_W-1:DATA_W],
                             Sout_DataRdy[CHANNELS-1:1]};

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        data_d  = data_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_base_addr;
                    cnt_d   = cmd_count;
                    size_d  = norm_size(cmd_size);
                    wait_d  = '0;
                    state_d = (cmd_count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // A response on the final allowed cycle still wins over the abort.
                if (Sout_DataRdy[0]) begin
                    data_d  = mask_word(Sout_Rdata_ram[DATA_W-1:0], size_q);
                    state_d = S_OUT;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    addr_d  = addr_q + addr_step;
                    wait_d  = '0;
                    state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from state only, so an asynchronous reset clears
    // the request and stream handshakes in the same cycle.
    always_comb begin
        cmd_ready       = (state_q == S_IDLE);
        S_oe_ram        = '0;
        S_addr_ram      = '0;
        S_data_ram_size = '0;
        if (state_q == S_REQ) begin
            S_oe_ram[0]                   = 1'b1;
            S_addr_ram[ADDR_W-1:0]        = addr_q;
            S_data_ram_size[SIZE_W-1:0]   = size_q;
        end
        out_valid = (state_q == S_OUT);
        out_data  = (state_q == S_OUT) ? data_q : '0;
        out_last  = (state_q == S_OUT) && (cnt_q == CNT_W'(1));
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERR);
    end

    assign S_we_ram    = '0;
    assign S_Wdata_ram = '0;

endmodule

// File: tb/tb_slave_ram_reader.sv
// ---------------------------------------------------------------------------
// tb_slave_ram_reader
//
// Randomised bench for slave_ram_reader. A byte-addressed memory array
// answers channel-0 reads after a programmable latency; a transaction-level
// model turns each command into the list of (address, word, last) the
// reader must produce, and one compare process checks requests, stream
// words, and done/error timing every cycle against it.
// ---------------------------------------------------------------------------
module tb_slave_ram_reader;

    localparam int CH = 2;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int SW = 7;
    localparam int CW = 16;
    localparam int TO = 64;

    logic                clock;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [AW-1:0]       cmd_base_addr;
    logic [CW-1:0]       cmd_count;
    logic [SW-1:0]       cmd_size;
    logic [CH-1:0]       S_oe_ram;
    logic [CH-1:0]       S_we_ram;
    logic [CH*AW-1:0]    S_addr_ram;
    logic [CH*DW-1:0]    S_Wdata_ram;
    logic [CH*SW-1:0]    S_data_ram_size;
    logic [CH*DW-1:0]    Sout_Rdata_ram;
    logic [CH-1:0]       Sout_DataRdy;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic                done;
    logic                error;

    slave_ram_reader #(
        .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW),
        .SIZE_W(SW), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_count(cmd_count), .cmd_size(cmd_size),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done), .error(error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    // Memory contents and environment knobs
    logic [DW-1:0] mem [512];
    bit  no_rsp   = 1'b0;
    bit  noise_en = 1'b0;
    int  lat_lo   = 0;
    int  lat_hi   = 0;
    int  rdy_pct  = 100;
    int  stall_word = -1;
    int  stall_total = 0;

    // Model of the command in flight (written by the stimulus only)
    exp_t          exp_q[$];
    int            exp_n   = 0;
    bit            exp_err = 1'b0;
    logic [SW-1:0] exp_sz  = '0;

    // Observations (written by the compare process only)
    int            req_idx = 0;
    int            acc_idx = 0;
    int            n_done  = 0;
    int            n_err   = 0;
    int            cyc     = 0;
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    logic          obs_last[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [63:0] oaddr(input int i);
        if (i < obs_addr.size()) return 64'(obs_addr[i]);
        return '1;
    endfunction

    function automatic logic [63:0] odata(input int i);
        if (i < obs_data.size()) return obs_data[i];
        return 64'hDEAD_BEEF_0BAD_F00D;
    endfunction

    function automatic logic [63:0] olast(input int i);
        if (i < obs_last.size()) return 64'(obs_last[i]);
        return '1;
    endfunction

    // Memory responder and stream consumer, driven just after each rising edge
    initial begin
        bit in_req;
        int lat_cnt;
        int cur_lat;
        int stall_cnt;
        in_req = 1'b0; lat_cnt = 0; cur_lat = 0; stall_cnt = 0;
        Sout_DataRdy = '0;
        Sout_Rdata_ram = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            Sout_Rdata_ram  = {$urandom(), $urandom(), $urandom(), $urandom()};
            Sout_DataRdy[1] = 1'($urandom_range(1, 0));
            Sout_DataRdy[0] = noise_en && ($urandom_range(3, 0) == 0);
            if (S_oe_ram[0] && !reset) begin
                Sout_DataRdy[0] = 1'b0;
                if (!in_req) begin
                    in_req  = 1'b1;
                    lat_cnt = 0;
                    cur_lat = int'($urandom_range(lat_hi, lat_lo));
                end
                if (!no_rsp && lat_cnt == cur_lat) begin
                    Sout_DataRdy[0]     = 1'b1;
                    Sout_Rdata_ram[DW-1:0] = mem[S_addr_ram[AW-1:0]];
                end
                lat_cnt++;
            end else begin
                in_req = 1'b0;
            end
            if (out_valid && acc_idx == stall_word && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
                stall_total++;
            end else begin
                if (acc_idx != stall_word) stall_cnt = 0;
                out_ready = ($urandom_range(99, 0) < rdy_pct);
            end
        end
    end

    // Compare process: outputs sampled on the falling edge
    initial begin
        bit            prev_oe, prev_valid, prev_ready, prev_last, prev_done, prev_err;
        logic [CH*AW-1:0] prev_addr;
        logic [DW-1:0] prev_data;
        int            cmd_acc_cyc, last_acc_cyc, oe_rise_cyc;
        prev_oe = 0; prev_valid = 0; prev_ready = 0; prev_last = 0;
        prev_done = 0; prev_err = 0; prev_addr = '0; prev_data = '0;
        cmd_acc_cyc = 0; last_acc_cyc = 0; oe_rise_cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                if (cmd_valid && cmd_ready) begin
                    cmd_acc_cyc = cyc;
                    req_idx = 0;
                    acc_idx = 0;
                    obs_addr.delete();
                    obs_data.delete();
                    obs_last.delete();
                end
                if (S_oe_ram[0] && !prev_oe) begin
                    obs_addr.push_back(S_addr_ram[AW-1:0]);
                    chk("req_after_accept", 64'(req_idx), 64'(acc_idx));
                    if (req_idx < exp_q.size()) begin
                        chk("req_addr", 64'(S_addr_ram[AW-1:0]), 64'(exp_q[req_idx].addr));
                        chk("req_size", 64'(S_data_ram_size[SW-1:0]), 64'(exp_sz));
                    end else begin
                        chk("req_extra", 64'(req_idx), 64'(exp_q.size()));
                    end
                    chk("we_zero", 64'(S_we_ram), 64'(0));
                    chk("wdata_zero", 64'(|S_Wdata_ram), 64'(0));
                    req_idx++;
                    oe_rise_cyc = cyc;
                end
                if (S_oe_ram[0] && prev_oe)
                    chk("req_addr_stable", 64'(S_addr_ram), 64'(prev_addr));
                if (out_valid) begin
                    chk("oe_during_out", 64'(S_oe_ram[0]), 64'(0));
                    if (prev_valid && !prev_ready) begin
                        chk("out_data_stable", out_data, prev_data);
                        chk("out_last_stable", 64'(out_last), 64'(prev_last));
                    end
                    if (out_ready) begin
                        obs_data.push_back(out_data);
                        obs_last.push_back(out_last);
                        if (acc_idx < exp_q.size()) begin
                            chk("out_data", out_data, exp_q[acc_idx].data);
                            chk("out_last", 64'(out_last), 64'(exp_q[acc_idx].last));
                        end else begin
                            chk("out_extra", 64'(acc_idx), 64'(exp_q.size()));
                        end
                        acc_idx++;
                        last_acc_cyc = cyc;
                    end
                end
                if (prev_done || prev_err)
                    chk("ready_after_end", 64'(cmd_ready), 64'(1));
                if (done) begin
                    chk("done_pulse_width", 64'(prev_done), 64'(0));
                    chk("done_not_expected_err", 64'(exp_err), 64'(0));
                    chk("done_all_requests", 64'(req_idx), 64'(exp_n));
                    chk("done_all_words", 64'(acc_idx), 64'(exp_n));
                    chk("done_latency",
                        64'((exp_n == 0) ? (cyc - cmd_acc_cyc) : (cyc - last_acc_cyc)), 64'(1));
                    n_done++;
                end
                if (error) begin
                    chk("error_expected", 64'(exp_err), 64'(1));
                    chk("error_latency", 64'(cyc - oe_rise_cyc), 64'(TO));
                    chk("error_oe_low", 64'(S_oe_ram[0]), 64'(0));
                    n_err++;
                end
            end
            prev_oe    = S_oe_ram[0];
            prev_addr  = S_addr_ram;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_done  = done;
            prev_err   = error;
        end
    end

    // Build the expected word list from the command and offer it to the DUT
    task automatic issue_cmd(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                             input logic [SW-1:0] sz, input bit want_err);
        int nsz;
        int k;
        exp_t e;
        logic [DW-1:0] m;
        nsz = (sz == 7'd8 || sz == 7'd16 || sz == 7'd32 || sz == 7'd64) ? int'(sz) : 64;
        if (nsz == 64) m = '1;
        else m = (64'd1 << nsz) - 64'd1;
        exp_q.delete();
        exp_sz  = SW'(nsz);
        exp_n   = int'(cnt);
        exp_err = want_err;
        for (int i = 0; i < int'(cnt); i++) begin
            e.addr = AW'(int'(base) + i * (nsz / 8));
            e.data = mem[e.addr] & m;
            e.last = (i == int'(cnt) - 1);
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        cmd_valid     = 1'b1;
        cmd_base_addr = base;
        cmd_count     = cnt;
        cmd_size      = sz;
        k = 0;
        forever begin
            @(negedge clock);
            if (cmd_ready) break;
            k++;
            if (k > 50) begin
                n_checks++;
                $display("FAIL cmd_accept: cmd_ready=0 for 50 cycles, required 1");
                break;
            end
        end
        @(posedge clock); #1;
        cmd_valid     = 1'b0;
        cmd_base_addr = AW'($urandom());
        cmd_count     = CW'($urandom());
        cmd_size      = SW'($urandom());
    endtask

    task automatic wait_end();
        int start;
        int k;
        start = n_done + n_err;
        k = 0;
        while (n_done + n_err == start && k < 2000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 2000) begin
            n_checks++;
            $display("FAIL cmd_end: no done/error within 2000 cycles, required one");
        end
        @(posedge clock); #1;
    endtask

    task automatic run_cmd(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                           input logic [SW-1:0] sz, input bit want_err);
        issue_cmd(base, cnt, sz, want_err);
        wait_end();
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int d0;
        int e0;
        int s0;
        int szs[6];
        szs = '{8, 16, 32, 64, 24, 0};
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_base_addr = '0;
        cmd_count = '0;
        cmd_size = '0;
        for (int i = 0; i < 512; i++) mem[i] = {$urandom(), $urandom()};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_oe", 64'(S_oe_ram), 64'(0));
        chk("rst_addr", 64'(S_addr_ram), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        reset = 1'b0;

        // Four 32-bit words from 0x10, memory answering two cycles after oe
        lat_lo = 2; lat_hi = 2; rdy_pct = 100;
        d0 = n_done;
        run_cmd(9'h010, 16'd4, 7'd32, 1'b0);
        chk("t2_done_count", 64'(n_done - d0), 64'(1));
        chk("t2_addr0", oaddr(0), 64'h010);
        chk("t2_addr1", oaddr(1), 64'h014);
        chk("t2_addr2", oaddr(2), 64'h018);
        chk("t2_addr3", oaddr(3), 64'h01C);
        chk("t2_words", 64'(obs_data.size()), 64'(4));
        chk("t2_last0", olast(0), 64'(0));
        chk("t2_last3", olast(3), 64'(1));
        chk("t2_word0", odata(0), {32'h0, mem[9'h010][31:0]});

        // Consumer holds off the second word for five cycles
        lat_lo = 1; lat_hi = 1;
        stall_word = 1;
        s0 = stall_total;
        run_cmd(9'h100, 16'd4, 7'd16, 1'b0);
        stall_word = -1;
        chk("t3_stall_cycles", 64'(stall_total - s0), 64'(5));
        chk("t3_words", 64'(obs_data.size()), 64'(4));

        // Zero-length command
        d0 = n_done;
        run_cmd(9'h033, 16'd0, 7'd32, 1'b0);
        chk("t4_done_count", 64'(n_done - d0), 64'(1));
        chk("t4_no_request", 64'(obs_addr.size()), 64'(0));

        // Memory never answers
        no_rsp = 1'b1;
        e0 = n_err;
        run_cmd(9'h020, 16'd3, 7'd16, 1'b1);
        no_rsp = 1'b0;
        chk("t5_error_count", 64'(n_err - e0), 64'(1));
        chk("t5_no_words", 64'(obs_data.size()), 64'(0));

        // Address wrap and byte-size masking
        lat_lo = 0; lat_hi = 3;
        run_cmd(9'h1FC, 16'd2, 7'd64, 1'b0);
        chk("t6_wrap_addr0", oaddr(0), 64'h1FC);
        chk("t6_wrap_addr1", oaddr(1), 64'h004);
        mem[9'h0A0] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_cmd(9'h0A0, 16'd1, 7'd8, 1'b0);
        chk("t6_byte_mask", odata(0), 64'h0000_0000_0000_00FF);
        run_cmd(9'h0F0, 16'd2, 7'd24, 1'b0);
        chk("t6_odd_size_step", oaddr(1), 64'h0F8);

        // Reset while a request is outstanding
        no_rsp = 1'b1;
        issue_cmd(9'h040, 16'd3, 7'd32, 1'b0);
        @(posedge clock); #1;
        chk("t1_oe_before_reset", 64'(S_oe_ram[0]), 64'(1));
        reset = 1'b1;
        #1;
        chk("t1_oe_dropped", 64'(S_oe_ram), 64'(0));
        chk("t1_valid_dropped", 64'(out_valid), 64'(0));
        chk("t1_done_low", 64'(done), 64'(0));
        chk("t1_error_low", 64'(error), 64'(0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        no_rsp = 1'b0;
        @(posedge clock); #1;
        chk("t1_ready_after_release", 64'(cmd_ready), 64'(1));
        repeat (3) @(posedge clock);
        #1;
        chk("t1_no_replay", 64'(S_oe_ram[0]), 64'(0));

        // Randomised commands with stray DataRdy and a bursty consumer
        noise_en = 1'b1;
        lat_lo = 0; lat_hi = 4; rdy_pct = 70;
        for (int t = 0; t < 30; t++) begin
            run_cmd(AW'($urandom_range(511, 0)), CW'($urandom_range(6, 0)),
                    SW'(szs[$urandom_range(5, 0)]), 1'b0);
        end
        no_rsp = 1'b1;
        e0 = n_err;
        run_cmd(AW'($urandom_range(511, 0)), CW'($urandom_range(5, 1)), 7'd64, 1'b1);
        no_rsp = 1'b0;
        chk("rand_timeout", 64'(n_err - e0), 64'(1));
        run_cmd(AW'($urandom_range(511, 0)), 16'd5, 7'd8, 1'b0);

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
